// File: rtl/pmp_check_arbiter_pkg.sv
// Shared types and mode encodings for the PMP check-lane arbiter.
package pmp_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2
    } pmp_arb_state_e;

    localparam logic [1:0] PMP_MODE_RSVD  = 2'b00;
    localparam logic [1:0] PMP_MODE_LOAD  = 2'b01;
    localparam logic [1:0] PMP_MODE_STORE = 2'b10;
    localparam logic [1:0] PMP_MODE_FETCH = 2'b11;

endpackage

// File: rtl/pmp_check_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or above rr_ptr, wrapping.
module pmp_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         elig,
    input  logic                 en,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int unsigned ID_W = $clog2(N);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en && !found && elig[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pmp_check_arbiter.sv
// Round-robin sharing of one PMP check lane with a one-entry issue stage and CSR-update drain.
module pmp_check_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][1:0]              req_mode,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    input  logic [NUM_REQ-1:0]                   rsp_ready,
    output logic [NUM_REQ-1:0]                   rsp_pass,
    output logic                                 chk_valid,
    output logic [ADDR_WIDTH-1:0]                chk_addr,
    output logic [1:0]                           chk_mode,
    input  logic                                 chk_pass,
    input  logic                                 cfg_update,
    output logic                                 busy
);

    import pmp_pkg::*;

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    pmp_arb_state_e          state;
    logic [ID_W-1:0]         rr_ptr;
    logic [NUM_REQ-1:0]      pend;
    logic [NUM_REQ-1:0]      elig;
    logic [NUM_REQ-1:0]      grant;
    logic [ID_W-1:0]         grant_id;
    logic                    arb_en;

    logic                    s_vld;
    logic [ID_W-1:0]         s_id;
    logic [ADDR_WIDTH-1:0]   s_addr;
    logic [1:0]              s_mode;

    assign elig   = req_valid & ~pend;
    // The cycle cfg_update is seen in RUN must already be grant-free.
    assign arb_en = (state == RUN) && !cfg_update && !rst;

    pmp_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .elig     (elig),
        .en       (arb_en),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;
    assign chk_valid = s_vld;
    assign chk_addr  = s_addr;
    assign chk_mode  = s_mode;
    assign busy      = s_vld | (|rsp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            rr_ptr    <= '0;
            pend      <= '0;
            s_vld     <= 1'b0;
            s_id      <= '0;
            s_addr    <= '0;
            s_mode    <= '0;
            rsp_valid <= '0;
            rsp_pass  <= '0;
        end else begin
            unique case (state)
                RUN:     if (cfg_update) state <= DRAIN;
                DRAIN:   if (!s_vld && !cfg_update) state <= SETTLE;
                SETTLE:  state <= cfg_update ? DRAIN : RUN;
                default: state <= RUN;
            endcase

            pend  <= (pend | grant) & ~(rsp_valid & rsp_ready);
            s_vld <= |grant;
            if (|grant) begin
                rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                s_id   <= grant_id;
                s_addr <= req_addr[grant_id];
                s_mode <= req_mode[grant_id];
            end

            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                    rsp_pass[i]  <= 1'b0;
                end
            end
            // pend guarantees s_id has no unaccepted result, so this never collides with the clear above.
            if (s_vld) begin
                rsp_valid[s_id] <= 1'b1;
                rsp_pass[s_id]  <= chk_pass && (s_mode != PMP_MODE_RSVD);
            end
        end
    end

endmodule
